addsub_seq: RTL and testbench

Parametrised, multi-cycle two's-complement adder/subtractor with a valid/ready handshake on both sides. A WIDTH-bit operation is processed CHUNK bits per cycle through a registered carry chain, so a wide add/sub fits a short critical path. It adds carry, signed-overflow and zero flags. It is the sequential, width-generic successor to the team's 4-bit ripple add/sub and sits in the datapath between operand registers and the result bus.

---
 rtl/addsub_pkg.sv | 6 +
 rtl/addsub_chunk.sv | 30 +++
 rtl/addsub_seq.sv | 96 +++++++++
 tb/tb_addsub_seq.sv | 129 ++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding and default sizing for the sequential add/sub.
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;
endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit ripple adder built from 1-bit full-adder cells.
module addsub_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_top
);
  logic [CHUNK:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    addsub_fa u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  assign co    = c[CHUNK];
  assign c_top = c[CHUNK-1];
endmodule

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle two's-complement add/sub, CHUNK bits per cycle through a
// registered carry, with valid/ready on both sides and carry/overflow/zero flags.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s_op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, s_q, s_d;
  logic [IW-1:0]    idx_q;
  logic             carry_q, in_ready_q, out_valid_q, cout_q, ovf_q, zero_q;
  logic [CHUNK-1:0] sum;
  logic             co, c_top, last;
  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a(a_q[int'(idx_q)*CHUNK +: CHUNK]),
    .b(b_q[int'(idx_q)*CHUNK +: CHUNK]),
    .ci(carry_q),
    .s(sum),
    .co(co),
    .c_top(c_top)
  );
  assign last = idx_q == IW'(NCHUNK - 1);
  always_comb begin
    s_d = s_q;
    s_d[int'(idx_q)*CHUNK +: CHUNK] = sum;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q        <= a;
          b_q        <= b ^ {WIDTH{s_op}};
          carry_q    <= cin;
          idx_q      <= '0;
          s_q        <= '0;
          in_ready_q <= 1'b0;
          state_q    <= RUN;
        end
        RUN: begin
          s_q     <= s_d;
          carry_q <= co;
          idx_q   <= idx_q + IW'(1);
          if (last) begin
            cout_q      <= co;
            ovf_q       <= c_top ^ co;
            zero_q      <= s_d == '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: directed vectors for addsub_seq at WIDTH=16, CHUNK=4.
module tb_addsub_seq;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, out_ready = 0, s_op = 0, cin = 0;
  logic [15:0] a = 0, b = 0;
  logic        in_ready, out_valid, cout, ovf, zero;
  logic [15:0] s;
  int          checks = 0, failures = 0;

  addsub_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s_op(s_op), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_timeout", 32'(in_ready), 1);
  endtask

  task automatic start(input logic [15:0] va, vb, input logic op, ci);
    wait_ready();
    a = va; b = vb; s_op = op; cin = ci; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    chk("busy_after_accept", 32'(in_ready), 0);
  endtask

  task automatic op(input string tag, input logic [15:0] va, vb, input logic sop, ci,
                    input logic [15:0] es, input logic ec, ev, ez);
    int lat = 0;
    start(va, vb, sop, ci);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_s"}, 32'(s), 32'(es));
    chk({tag, "_flags"}, {29'd0, cout, ovf, zero}, {29'd0, ec, ev, ez});
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  logic [15:0] va[3] = '{16'h0101, 16'h4000, 16'hFFF0};
  logic [15:0] vb[3] = '{16'h0202, 16'h4000, 16'h0020};
  logic [15:0] ve[3] = '{16'h0303, 16'h8000, 16'h0010};
  int acc_t[3];

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_outs", {14'd0, s, out_valid, cout, ovf, zero}, 0);
    rst = 0;
    @(negedge clk);
    op("add_small", 16'h1234, 16'h0001, 0, 0, 16'h1235, 0, 0, 0);
    op("add_wrap", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
    op("add_ovf", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0);
    op("sub_eq", 16'h0005, 16'h0005, 1, 1, 16'h0000, 1, 0, 1);
    op("sub_ovf", 16'h8000, 16'h0001, 1, 1, 16'h7FFF, 1, 1, 0);
    op("sub_borrow", 16'h1234, 16'h1235, 1, 1, 16'hFFFF, 0, 0, 0);

    // backpressure: result held in DONE while inputs churn
    start(16'h00F0, 16'h000F, 0, 0);
    repeat (4) @(negedge clk);
    chk("bp_valid", 32'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; a = 16'(i * 16'h1111); b = ~a;
      @(negedge clk);
      chk("bp_s", 32'(s), 32'h00FF);
      chk("bp_hold", {29'd0, out_valid, in_ready, zero}, {29'd0, 3'b100});
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("bp_release", {30'd0, out_valid, in_ready}, 32'b01);
    op("bp_next", 16'h0010, 16'h0020, 0, 0, 16'h0030, 0, 0, 0);

    // reset two cycles into RUN aborts the operation
    start(16'h1111, 16'h2222, 0, 0);
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_run_ready", {30'd0, out_valid, in_ready}, 32'b01);
    chk("rst_run_outs", {13'd0, s, cout, ovf, zero}, 0);
    @(negedge clk);
    rst = 0;
    op("post_rst", 16'h0003, 16'h0004, 0, 0, 16'h0007, 0, 0, 0);

    // back-to-back with in_valid and out_ready held high
    begin
      int n_acc = 0, n_res = 0;
      out_ready = 1; s_op = 0; cin = 0; in_valid = 1;
      for (int c = 0; c < 40; c++) begin
        if (in_ready) begin
          if (n_acc < 3) begin
            a = va[n_acc]; b = vb[n_acc]; acc_t[n_acc] = c; n_acc++;
          end else in_valid = 0;
        end
        if (out_valid && n_res < 3) begin
          chk("b2b_s", 32'(s), 32'(ve[n_res]));
          n_res++;
        end
        @(negedge clk);
      end
      chk("b2b_results", n_res, 3);
      chk("b2b_gap1", acc_t[1] - acc_t[0], 6);
      chk("b2b_gap2", acc_t[2] - acc_t[1], 6);
      out_ready = 0; in_valid = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
